// File: rtl/peripheral_mult_mac.sv
// Memory-mapped multiply / multiply-accumulate peripheral for the j1 I/O bus.
// Sequential radix-2 shift-add engine; optional interrupt output under `MULT_IRQ_EN`.
module peripheral_mult_mac #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
`ifdef MULT_IRQ_EN
  output logic        irq,
`endif
  output logic [15:0] d_out
);

  localparam int unsigned NW = WIDTH / 16;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    p_q;
  logic             sgn_mode, acc_mode, irq_en;
  logic             done, busy, ovf;

  logic [PW-1:0]    mcand, prod;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic             wr_en, ctrl_wr, load, step, fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    prod_s;
  logic [PW:0]      sum;
  logic             sum_ovf;
  logic [15:0]      rdata;

  assign wr_en = cs && wr;
  // CTRL writes are dropped entirely while an operation is in flight
  assign ctrl_wr = wr_en && (addr == 4'h4) && (state == IDLE);

  // Next-state and engine strobes
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && d_in[0]) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes (signedness taken from the start write itself) and final sum
  always_comb begin
    a_mag = a_q;
    b_mag = b_q;
    if (d_in[1] && a_q[WIDTH-1]) a_mag = -a_q;
    if (d_in[1] && b_q[WIDTH-1]) b_mag = -b_q;
    prod_s  = neg ? -prod : prod;
    sum     = {1'b0, p_q} + {1'b0, prod_s};
    sum_ovf = sgn_mode ? ((p_q[PW-1] == prod_s[PW-1]) && (sum[PW-1] != p_q[PW-1]))
                       : sum[PW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Operand registers; writable at any time, sampled only at start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (addr == 4'(i))     a_q[16*i +: 16] <= d_in;
        if (addr == 4'(2 + i)) b_q[16*i +: 16] <= d_in;
      end
    end
  end

  // Shift-add engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= PW'(a_mag);
      mplier <= b_mag;
      prod   <= '0;
      neg    <= d_in[1] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      cnt    <= '0;
    end else if (step) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // Control, status and product registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q      <= '0;
      sgn_mode <= 1'b0;
      acc_mode <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else if (ctrl_wr) begin
      sgn_mode <= d_in[1];
      acc_mode <= d_in[2];
      irq_en   <= d_in[3];
      if (d_in[5]) begin
        p_q <= '0;
        ovf <= 1'b0;
      end
      if (d_in[4] || d_in[0]) done <= 1'b0;
      if (d_in[0]) busy <= 1'b1;
    end else if (fix) begin
      if (acc_mode) begin
        p_q <= sum[PW-1:0];
        if (sum_ovf) ovf <= 1'b1;
      end else begin
        p_q <= prod_s;
      end
      done <= 1'b1;
      busy <= 1'b0;
    end
  end

`ifdef MULT_IRQ_EN
  // Tracks done && irq_en using the values those registers take on this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq <= 1'b0;
    else if (ctrl_wr) irq <= d_in[3] & done & ~d_in[4] & ~d_in[0];
    else if (fix)     irq <= irq_en;
  end
`endif

  // Read mux
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (addr == 4'(i))     rdata = a_q[16*i +: 16];
      if (addr == 4'(2 + i)) rdata = b_q[16*i +: 16];
    end
    for (int unsigned i = 0; i < 2 * NW; i++) begin
      if (addr == 4'(8 + i)) rdata = p_q[16*i +: 16];
    end
    if (addr == 4'h5) rdata = {10'b0, irq_en, acc_mode, sgn_mode, ovf, busy, done};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           d_out <= '0;
    else if (cs && rd)  d_out <= rdata;
    else                d_out <= '0;
  end

endmodule

// File: tb/tb_peripheral_mult_mac.sv
// Directed bench for peripheral_mult_mac: WIDTH=16 and WIDTH=32 instances on one bus,
// table of product/MAC vectors plus timing, busy-hazard, reset and irq sequences.
module tb_peripheral_mult_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic [3:0]  addr;
  logic        rd, wr, cs0, cs1;
  logic [15:0] dout0, dout1;
`ifdef MULT_IRQ_EN
  logic        irq0, irq1;
`endif

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  peripheral_mult_mac #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs0), .addr(addr), .rd(rd), .wr(wr),
`ifdef MULT_IRQ_EN
    .irq(irq0),
`endif
    .d_out(dout0)
  );

  peripheral_mult_mac #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs1), .addr(addr), .rd(rd), .wr(wr),
`ifdef MULT_IRQ_EN
    .irq(irq1),
`endif
    .d_out(dout1)
  );

  typedef struct {
    int          sel;
    bit          sgn;
    bit          acc;
    bit          clr;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    bit          ovf;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;
  endtask

  task automatic bus_write(input int sel, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs0 = (sel == 0); cs1 = (sel == 1); wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int sel, input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    cs0 = (sel == 0); cs1 = (sel == 1); wr = 1'b0; rd = 1'b1; addr = a;
    @(negedge clk);
    d = (sel == 1) ? dout1 : dout0;
    bus_idle();
  endtask

  task automatic read_p(input int sel, output logic [63:0] p);
    logic [15:0] w;
    p = '0;
    for (int i = 0; i < ((sel == 1) ? 4 : 2); i++) begin
      bus_read(sel, 4'(8 + i), w);
      p[16*i +: 16] = w;
    end
  endtask

  // Poll STATUS each cycle from just after the start edge; edges = read edge index showing done
  task automatic poll_done(input int sel, output int edges, output bit busy_ok);
    logic [15:0] d;
    edges = 0;
    busy_ok = 1'b1;
    cs0 = (sel == 0); cs1 = (sel == 1); wr = 1'b0; rd = 1'b1; addr = 4'h5;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      d = (sel == 1) ? dout1 : dout0;
      if (d[0]) begin
        edges = k;
        break;
      end
      if (!d[1]) busy_ok = 1'b0;
    end
    bus_idle();
  endtask

  initial begin
    logic [15:0] w;
    logic [63:0] p;
    int          edges, first_done;
    bit          busy_ok;
    logic [15:0] exp_st;

    //          sel sgn acc clr  a              b              p                        ovf
    vt[0]  = '{0, 0, 0, 0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 0};
    vt[1]  = '{0, 0, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 0};
    vt[2]  = '{0, 1, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_0000_0001, 0};
    vt[3]  = '{0, 1, 0, 0, 32'h0000_FFFE, 32'h0000_0003, 64'h0000_0000_FFFF_FFFA, 0};
    vt[4]  = '{0, 1, 0, 0, 32'h0000_8000, 32'h0000_8000, 64'h0000_0000_4000_0000, 0};
    vt[5]  = '{0, 1, 0, 0, 32'h0000_8000, 32'h0000_0001, 64'h0000_0000_FFFF_8000, 0};
    vt[6]  = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_1234, 64'h0000_0000_0000_0000, 0};
    vt[7]  = '{0, 0, 1, 1, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 0};
    vt[8]  = '{0, 0, 1, 0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFC_0002, 1};
    vt[9]  = '{0, 0, 1, 0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFA_0003, 1};
    vt[10] = '{0, 0, 1, 0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFF8_0004, 1};
    vt[11] = '{1, 0, 0, 0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 0};
    vt[12] = '{1, 1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 0};
    vt[13] = '{0, 1, 1, 1, 32'h0000_8000, 32'h0000_8000, 64'h0000_0000_4000_0000, 0};
    vt[14] = '{0, 1, 1, 0, 32'h0000_8000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1};

    rst = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    check("reset_dout16", 64'(dout0), 64'h0);
    rst = 1'b1;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      bus_read(s, 4'h5, w);
      check($sformatf("reset_status_%0d", s), 64'(w), 64'h0);
      read_p(s, p);
      check($sformatf("reset_p_%0d", s), p, 64'h0);
      bus_read(s, 4'h0, w);
      check($sformatf("reset_a_%0d", s), 64'(w), 64'h0);
    end

    // Table-driven products and MAC sequences
    for (int v = 0; v < 15; v++) begin
      for (int i = 0; i < ((vt[v].sel == 1) ? 2 : 1); i++) begin
        bus_write(vt[v].sel, 4'(i), vt[v].a[16*i +: 16]);
        bus_write(vt[v].sel, 4'(2 + i), vt[v].b[16*i +: 16]);
      end
      bus_write(vt[v].sel, 4'h4, {10'b0, vt[v].clr, 1'b0, 1'b0, vt[v].acc, vt[v].sgn, 1'b1});
      poll_done(vt[v].sel, edges, busy_ok);
      check($sformatf("v%0d_done_edge", v), 64'(edges), 64'((vt[v].sel == 1) ? 34 : 18));
      check($sformatf("v%0d_busy_before_done", v), 64'(busy_ok), 64'h1);
      read_p(vt[v].sel, p);
      check($sformatf("v%0d_p", v), p, vt[v].p);
      exp_st = 16'h0001;
      exp_st[4] = vt[v].acc;
      exp_st[3] = vt[v].sgn;
      exp_st[2] = vt[v].ovf;
      bus_read(vt[v].sel, 4'h5, w);
      check($sformatf("v%0d_status", v), 64'(w), 64'(exp_st));
    end

    // Busy hazards: A write, second start with clr_acc, P read mid-operation
    bus_write(0, 4'h0, 16'h0003);
    bus_write(0, 4'h2, 16'h0005);
    bus_write(0, 4'h4, 16'h0001);
    first_done = 0;
    for (int k = 1; k <= 60; k++) begin
      cs0 = 1'b1; cs1 = 1'b0; d_in = 16'h0;
      if (k == 3) begin
        wr = 1'b1; rd = 1'b0; addr = 4'h0; d_in = 16'h0007;
      end else if (k == 5) begin
        wr = 1'b1; rd = 1'b0; addr = 4'h4; d_in = 16'h0027;
      end else if (k == 7) begin
        wr = 1'b0; rd = 1'b1; addr = 4'h9;
      end else begin
        wr = 1'b0; rd = 1'b1; addr = 4'h5;
      end
      @(negedge clk);
      if (k == 7) check("busy_p_read_prev", 64'(dout0), 64'h8000);
      else if (k != 3 && k != 5 && dout0[0]) begin
        first_done = k;
        break;
      end
    end
    bus_idle();
    check("hazard_done_edge", 64'(first_done), 64'd18);
    read_p(0, p);
    check("hazard_p", p, 64'h0000_000F);
    bus_read(0, 4'h5, w);
    check("hazard_status", 64'(w), 64'h0005);
    bus_read(0, 4'h0, w);
    check("a_write_while_busy", 64'(w), 64'h0007);
    bus_read(0, 4'h6, w);
    check("unused_read", 64'(w), 64'h0);
    bus_read(0, 4'h4, w);
    check("ctrl_read_zero", 64'(w), 64'h0);

    // clr_acc then clr_done
    bus_write(0, 4'h4, 16'h0020);
    read_p(0, p);
    check("clr_acc_p", p, 64'h0);
    bus_read(0, 4'h5, w);
    check("clr_acc_status", 64'(w), 64'h0001);
    bus_write(0, 4'h4, 16'h0010);
    bus_read(0, 4'h5, w);
    check("clr_done_status", 64'(w), 64'h0000);

    // Reset in the middle of an operation (A=7, B=5)
    bus_write(0, 4'h4, 16'h0001);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_mid_dout", 64'(dout0), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    read_p(0, p);
    check("rst_mid_p", p, 64'h0);
    bus_read(0, 4'h5, w);
    check("rst_mid_status", 64'(w), 64'h0);
    bus_write(0, 4'h0, 16'h0007);
    bus_write(0, 4'h2, 16'h0005);
    bus_write(0, 4'h4, 16'h0001);
    poll_done(0, edges, busy_ok);
    check("post_rst_done_edge", 64'(edges), 64'd18);
    read_p(0, p);
    check("post_rst_p", p, 64'h23);

`ifdef MULT_IRQ_EN
    bus_write(1, 4'h0, 16'h0002);
    bus_write(1, 4'h1, 16'h0001);
    bus_write(1, 4'h2, 16'h0004);
    bus_write(1, 4'h3, 16'h0003);
    bus_write(1, 4'h4, 16'h0009);
    check("irq_low_while_busy", 64'(irq1), 64'h0);
    poll_done(1, edges, busy_ok);
    check("irq_done_edge", 64'(edges), 64'd34);
    check("irq_high", 64'(irq1), 64'h1);
    check("irq_other_low", 64'(irq0), 64'h0);
    bus_write(1, 4'h4, 16'h0018);
    check("irq_after_clr_done", 64'(irq1), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
